// File: rtl/uart_echo_tester.sv
// UART loopback self-test initiator: sends a SEED-based incrementing byte pattern,
// waits for each echo, and tallies matches, mismatches and timeouts.
module uart_echo_tester #(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         UART_BPS  = 115200,
    parameter int         NUM_BYTES = 256,
    parameter logic [7:0] SEED      = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        send_en,
    output logic [7:0]  send_data,
    input  logic        tx_busy,
    input  logic        recv_done,
    input  logic [7:0]  recv_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [15:0] err_cnt,
    output logic        timeout_seen
);

    localparam int TIMEOUT = (CLK_FREQ / UART_BPS) * 40;
    localparam int TW      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ECHO,
        FINISH
    } state_t;

    state_t        state, state_next;
    logic [15:0]   index, index_next;
    logic [TW-1:0] timer, timer_next;
    logic          send_en_next;
    logic [7:0]    send_data_next;
    logic          busy_next;
    logic          done_next;
    logic [15:0]   pass_next;
    logic [15:0]   err_next;
    logic          timeout_next;
    logic          byte_event;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            index        <= '0;
            timer        <= '0;
            send_en      <= 1'b0;
            send_data    <= SEED;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_cnt     <= '0;
            err_cnt      <= '0;
            timeout_seen <= 1'b0;
        end else begin
            state        <= state_next;
            index        <= index_next;
            timer        <= timer_next;
            send_en      <= send_en_next;
            send_data    <= send_data_next;
            busy         <= busy_next;
            done         <= done_next;
            pass_cnt     <= pass_next;
            err_cnt      <= err_next;
            timeout_seen <= timeout_next;
        end
    end

    // A received byte takes priority over a timeout expiring in the same cycle.
    always_comb begin
        state_next     = state;
        index_next     = index;
        timer_next     = timer;
        send_en_next   = 1'b0;
        send_data_next = send_data;
        busy_next      = busy;
        done_next      = 1'b0;
        pass_next      = pass_cnt;
        err_next       = err_cnt;
        timeout_next   = timeout_seen;
        byte_event     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = SEND;
                    busy_next    = 1'b1;
                    pass_next    = '0;
                    err_next     = '0;
                    timeout_next = 1'b0;
                    index_next   = '0;
                end
            end

            SEND: begin
                if (!tx_busy) begin
                    send_data_next = SEED + index[7:0];
                    send_en_next   = 1'b1;
                    timer_next     = '0;
                    state_next     = WAIT_ECHO;
                end
            end

            WAIT_ECHO: begin
                timer_next = timer + TW'(1);
                if (recv_done) begin
                    byte_event = 1'b1;
                    if (recv_data == send_data) begin
                        pass_next = sat_inc(pass_cnt);
                    end else begin
                        err_next = sat_inc(err_cnt);
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    byte_event   = 1'b1;
                    err_next     = sat_inc(err_cnt);
                    timeout_next = 1'b1;
                end

                if (byte_event) begin
                    if (index == 16'(NUM_BYTES - 1)) begin
                        state_next = FINISH;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        index_next = index + 16'd1;
                        state_next = SEND;
                    end
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: a loopback echo model feeds the receiver side
// and a queue of expected pattern bytes checks every transmit request.
module tb_uart_echo_tester;

    localparam logic [7:0] SEED = 8'hFE;
    localparam int         NUM  = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic        send_en;
    logic [7:0]  send_data;
    logic        tx_busy;
    logic        recv_done;
    logic [7:0]  recv_data;
    logic        busy;
    logic        done;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic        timeout_seen;

    logic        model_done = 1'b0;
    logic [7:0]  model_data = 8'h00;
    logic        stray_done = 1'b0;
    logic [7:0]  stray_data = 8'h00;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int send_count = 0;
    int send_cyc   = 0;
    int run_base   = 0;
    int corrupt_idx = -1;
    int drop_idx    = -1;
    int slow_idx    = -1;
    int slow_delay  = 19;
    int m_idx;
    logic [7:0] m_exp;
    bit got;
    bit early;
    int exp_err;

    assign recv_done = model_done | stray_done;
    assign recv_data = stray_done ? stray_data : model_data;

    uart_echo_tester #(
        .CLK_FREQ (1000),
        .UART_BPS (100),
        .NUM_BYTES(NUM),
        .SEED     (SEED)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (start),
        .send_en     (send_en),
        .send_data   (send_data),
        .tx_busy     (tx_busy),
        .recv_done   (recv_done),
        .recv_data   (recv_data),
        .busy        (busy),
        .done        (done),
        .pass_cnt    (pass_cnt),
        .err_cnt     (err_cnt),
        .timeout_seen(timeout_seen)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Loopback model: pops the expected byte on every send_en and echoes after a delay.
    always begin
        @(negedge sys_clk);
        if (send_en) begin
            m_idx    = send_count - run_base;
            send_cyc = cyc;
            send_count++;
            checkOutput("sb_underflow", 32'(exp_q.size() == 0), 0);
            if (exp_q.size() != 0) begin
                m_exp = exp_q.pop_front();
                checkOutput("send_data", 32'(send_data), 32'(m_exp));
            end
            if (m_idx != drop_idx) begin
                repeat ((m_idx == slow_idx) ? slow_delay : 19) @(posedge sys_clk);
                @(negedge sys_clk);
                model_data = (m_idx == corrupt_idx) ? (send_data ^ 8'h01) : send_data;
                model_done = 1'b1;
                @(negedge sys_clk);
                model_done = 1'b0;
            end
        end
    end

    task automatic setModel(input int c, input int d, input int s);
        corrupt_idx = c;
        drop_idx    = d;
        slow_idx    = s;
        slow_delay  = 399;
    endtask

    task automatic applyStimulus();
        exp_q.delete();
        for (int i = 0; i < NUM; i++) exp_q.push_back(SEED + 8'(i));
        run_base = send_count;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 1);
        checkOutput("pass_cleared", 32'(pass_cnt), 0);
        checkOutput("err_cleared", 32'(err_cnt), 0);
        checkOutput("timeout_cleared", 32'(timeout_seen), 0);
    endtask

    task automatic waitDone(input int exp_pass, input int exp_err_v, input int exp_to);
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge sys_clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 32'(got), 1);
        checkOutput("busy_low_with_done", 32'(busy), 0);
        checkOutput("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
        checkOutput("err_cnt", 32'(err_cnt), 32'(exp_err_v));
        checkOutput("timeout_seen", 32'(timeout_seen), 32'(exp_to));
        checkOutput("sb_empty", 32'(exp_q.size()), 0);
        checkOutput("sends_in_run", 32'(send_count - run_base), NUM);
        @(negedge sys_clk);
        checkOutput("done_single_pulse", 32'(done), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_send_en"}, 32'(send_en), 0);
        checkOutput({tag, "_send_data"}, 32'(send_data), 32'(SEED));
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_pass"}, 32'(pass_cnt), 0);
        checkOutput({tag, "_err"}, 32'(err_cnt), 0);
        checkOutput({tag, "_timeout"}, 32'(timeout_seen), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sys_rst_n = 1'b1;
        start     = 1'b0;
        tx_busy   = 1'b0;
        #1 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checkResetValues("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        $display("[TB] clean loop");
        setModel(-1, -1, -1);
        applyStimulus();
        @(negedge sys_clk);
        checkOutput("send_en_latency", 32'(send_en), 1);
        waitDone(4, 0, 0);

        $display("[TB] stray recv_done in IDLE");
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            stray_data = SEED + 8'(k);
            stray_done = 1'b1;
            @(negedge sys_clk);
            stray_done = 1'b0;
        end
        @(negedge sys_clk);
        checkOutput("stray_pass", 32'(pass_cnt), 4);
        checkOutput("stray_err", 32'(err_cnt), 0);
        checkOutput("stray_busy", 32'(busy), 0);

        $display("[TB] corrupted third echo");
        setModel(2, -1, -1);
        applyStimulus();
        waitDone(3, 1, 0);

        $display("[TB] dropped third byte");
        setModel(-1, 2, -1);
        applyStimulus();
        got = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge sys_clk);
            if (err_cnt != 16'd0) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("timeout_reached", 32'(got), 1);
        checkOutput("timeout_latency", 32'(cyc - send_cyc), 400);
        checkOutput("timeout_byte", 32'(send_count - run_base), 3);
        checkOutput("timeout_flag", 32'(timeout_seen), 1);
        waitDone(3, 1, 1);

        $display("[TB] echo on last timer cycle");
        setModel(-1, -1, 1);
        applyStimulus();
        waitDone(4, 0, 0);

        $display("[TB] tx_busy holds transmission");
        setModel(-1, -1, -1);
        tx_busy = 1'b1;
        applyStimulus();
        early = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge sys_clk);
            if (send_en) early = 1'b1;
        end
        checkOutput("no_send_while_busy", 32'(early), 0);
        tx_busy = 1'b0;
        @(negedge sys_clk);
        checkOutput("send_after_busy", 32'(send_en), 1);
        waitDone(4, 0, 0);

        $display("[TB] reset mid-run");
        applyStimulus();
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge sys_clk);
            if (send_count - run_base >= 2) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("second_send_seen", 32'(got), 1);
        #1;
        checkOutput("pass_before_reset", 32'(pass_cnt), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        checkResetValues("idle_after_reset");
        applyStimulus();
        waitDone(4, 0, 0);

        $display("[TB] err_cnt saturation");
        setModel(0, -1, -1);
        applyStimulus();
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge sys_clk);
            if (send_count - run_base >= 1) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("first_send_seen", 32'(got), 1);
        @(negedge sys_clk);
        force dut.err_cnt = 16'hFFFF;
        @(negedge sys_clk);
        release dut.err_cnt;
        exp_err = 32'hFFFF;
        waitDone(3, exp_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
